clock_disp_scan: RTL and testbench

- Reads the clock's BCD time digits (hours, minutes, seconds) and drives a 6-digit multiplexed, common-anode 7-segment display.
- Scans one digit at a time and latches a coherent time snapshot once per frame.
- Blinks the field selected for time-setting, blinks the colon points at the 1 Hz phase, and optionally blanks the hour-tens leading zero.
- Sits between the sec/min/hour counters and the board display pins.

---
 rtl/clock_disp_pkg.sv | 46 ++++
 rtl/clock_disp_scan_seg7_dec.sv | 26 ++
 rtl/clock_disp_scan.sv | 101 ++++++++++
 tb/tb_clock_disp_scan.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed clock display: segment patterns,
// digit positions and time-set field encodings.
package clock_disp_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {
    DIG_HH = 3'd0,
    DIG_HL = 3'd1,
    DIG_MH = 3'd2,
    DIG_ML = 3'd3,
    DIG_SH = 3'd4,
    DIG_SL = 3'd5
  } dig_e;

  typedef enum logic [1:0] {
    SET_NONE = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } setsel_e;

  // Time-set field that a digit position belongs to; never SET_NONE.
  function automatic setsel_e field_of(input dig_e d);
    setsel_e f;
    case (d)
      DIG_HH, DIG_HL: f = SET_HOUR;
      DIG_MH, DIG_ML: f = SET_MIN;
      default:        f = SET_SEC;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/clock_disp_scan_seg7_dec.sv
// BCD to active-low 7-segment decoder; codes above 9 show a dash.
module seg7_dec
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed common-anode display driver for the HH:MM:SS clock,
// with per-frame time snapshot, set-field blinking and leading-zero blanking.
module clock_disp_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] HH,
  input  logic [3:0] HL,
  input  logic [2:0] MH,
  input  logic [3:0] ML,
  input  logic [2:0] SH,
  input  logic [3:0] SL,
  input  logic       en1hz,
  input  logic [1:0] SETSEL,
  input  logic       LZB,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [5:0] AN
);

  localparam int unsigned   PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0]   presc;
  logic            tick;
  dig_e            idx;
  logic            phase;
  logic [5:0][3:0] snap;

  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;
  logic       blank_field;
  logic       blank_lz;
  logic [5:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign tick = (presc == PRE_MAX);

  always_ff @(posedge CLK) begin
    if (RST)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST)       idx <= DIG_HH;
    else if (tick) idx <= (idx == DIG_SL) ? DIG_HH : dig_e'(idx + 3'd1);
  end

  // Whole time is captured only at frame wrap so one frame never mixes two seconds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snap <= '0;
    end else if (tick && idx == DIG_SL) begin
      snap[DIG_HH] <= {2'b00, HH};
      snap[DIG_HL] <= HL;
      snap[DIG_MH] <= {1'b0, MH};
      snap[DIG_ML] <= ML;
      snap[DIG_SH] <= {1'b0, SH};
      snap[DIG_SL] <= SL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)        phase <= 1'b0;
    else if (en1hz) phase <= ~phase;
  end

  assign cur_bcd = snap[idx];

  seg7_dec u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    an_d        = '1;
    an_d[idx]   = 1'b0;
    blank_field = phase && (setsel_e'(SETSEL) == field_of(idx));
    blank_lz    = (idx == DIG_HH) && LZB && (snap[DIG_HH] == 4'd0);
    seg_d       = (blank_field || blank_lz) ? SEG_BLANK : dec_seg;
    dp_d        = ~(((idx == DIG_HL) || (idx == DIG_ML)) && !phase);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= '1;
      SEG <= SEG_BLANK;
      DP  <= 1'b1;
    end else begin
      AN  <= an_d;
      SEG <= seg_d;
      DP  <= dp_d;
    end
  end

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed bench for clock_disp_scan with SCAN_DIV = 4; per-cycle expected
// display words are queued and compared one cycle after each clock edge.
module tb_clock_disp_scan;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] HH;
  logic [3:0] HL;
  logic [2:0] MH;
  logic [3:0] ML;
  logic [2:0] SH;
  logic [3:0] SL;
  logic       en1hz;
  logic [1:0] SETSEL;
  logic       LZB;
  logic [6:0] SEG;
  logic       DP;
  logic [5:0] AN;

  always #5 CLK = ~CLK;

  clock_disp_scan #(.SCAN_DIV(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .HH     (HH),
    .HL     (HL),
    .MH     (MH),
    .ML     (ML),
    .SH     (SH),
    .SL     (SL),
    .en1hz  (en1hz),
    .SETSEL (SETSEL),
    .LZB    (LZB),
    .SEG    (SEG),
    .DP     (DP),
    .AN     (AN)
  );

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [5:0] an_for(input int d);
    logic [5:0] a;
    a    = '1;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic push_exp(input string tag, input logic [5:0] an,
                          input logic [6:0] seg, input logic dp);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    e.dp  = dp;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cyc_check();
    exp_t  e;
    string t;
    @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: no expected value queued, got AN=%b SEG=%b DP=%b", AN, SEG, DP);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert ({AN, SEG, DP} === {e.an, e.seg, e.dp}) else begin
        errors++;
        $error("FAIL %s: got AN=%b SEG=%b DP=%b, expected AN=%b SEG=%b DP=%b",
               t, AN, SEG, DP, e.an, e.seg, e.dp);
      end
    end
  endtask

  // n cycles of digit d; bcd holds digits 0..5 from the top nibble down
  task automatic dg(input string tag, input logic [23:0] bcd, input logic [5:0] blk,
                    input logic ph, input int d, input int n);
    logic [6:0] s;
    logic       p;
    s = blk[d] ? 7'b1111111 : seg_of(bcd[23-4*d -: 4]);
    p = (!ph && (d == 1 || d == 3)) ? 1'b0 : 1'b1;
    repeat (n) begin
      push_exp(tag, an_for(d), s, p);
      cyc_check();
    end
  endtask

  task automatic frame(input string tag, input logic [23:0] bcd,
                       input logic [5:0] blk, input logic ph);
    for (int d = 0; d < 6; d++) dg(tag, bcd, blk, ph, d, 4);
  endtask

  task automatic rst_chk(input string tag, input int n);
    repeat (n) begin
      push_exp(tag, 6'b111111, 7'b1111111, 1'b1);
      cyc_check();
    end
  endtask

  initial begin
    RST = 1'b1; en1hz = 1'b0; SETSEL = 2'b00; LZB = 1'b0;
    HH = 2'd1; HL = 4'd2; MH = 3'd3; ML = 4'd4; SH = 3'd5; SL = 4'd6;

    rst_chk("reset_hold", 3);
    RST = 1'b0;

    frame("frame1_zero", 24'h000000, 6'b000000, 1'b0);
    frame("frame2_123456", 24'h123456, 6'b000000, 1'b0);

    dg("frame3_coherent", 24'h123456, 6'b000000, 1'b0, 0, 4);
    dg("frame3_coherent", 24'h123456, 6'b000000, 1'b0, 1, 4);
    dg("frame3_coherent", 24'h123456, 6'b000000, 1'b0, 2, 2);
    ML = 4'd7;
    dg("frame3_coherent", 24'h123456, 6'b000000, 1'b0, 2, 2);
    for (int d = 3; d < 6; d++) dg("frame3_coherent", 24'h123456, 6'b000000, 1'b0, d, 4);

    SETSEL = 2'b10;
    for (int d = 0; d < 5; d++) dg("frame4_new_ml", 24'h123756, 6'b000000, 1'b0, d, 4);
    dg("frame4_new_ml", 24'h123756, 6'b000000, 1'b0, 5, 2);
    en1hz = 1'b1;
    dg("frame4_pulse", 24'h123756, 6'b000000, 1'b0, 5, 1);
    en1hz = 1'b0;
    dg("frame4_pulse", 24'h123756, 6'b000000, 1'b1, 5, 1);

    for (int d = 0; d < 5; d++) dg("frame5_blink_min", 24'h123756, 6'b001100, 1'b1, d, 4);
    dg("frame5_blink_min", 24'h123756, 6'b001100, 1'b1, 5, 3);
    en1hz = 1'b1;
    dg("frame5_pulse_on_tick", 24'h123756, 6'b001100, 1'b1, 5, 1);
    en1hz = 1'b0;

    SETSEL = 2'b00; LZB = 1'b1; HH = 2'd0; HL = 4'd11;
    frame("frame6_restored", 24'h123756, 6'b000000, 1'b0);
    frame("frame7_lzb_dash", 24'h0B3756, 6'b000001, 1'b0);

    LZB = 1'b0;
    for (int d = 0; d < 4; d++) dg("frame8_lzb_off", 24'h0B3756, 6'b000000, 1'b0, d, 4);
    dg("frame8_lzb_off", 24'h0B3756, 6'b000000, 1'b0, 4, 2);
    RST = 1'b1;
    rst_chk("reset_mid_scan", 1);
    RST = 1'b0;
    dg("after_reset_zero", 24'h000000, 6'b000000, 1'b0, 0, 4);
    dg("after_reset_zero", 24'h000000, 6'b000000, 1'b0, 1, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
